fnv1a_stream_hasher: RTL

//   Parametrised streaming FNV-1a hash engine with a side XOR-LRC, the core for the next-generation tt_um hash project.
//   - Absorbs a byte stream over a valid/ready handshake.
//   - Framing is explicit: in_last closes a message.
//   - Emits the HASH_W-bit digest MSB-first, one byte per handshake, on an 8-bit valid/ready output suited to uo_out/uio pins.
//   - The top-level tt_um wrapper maps ui_in/uio_in/uo_out onto these ports.

---
 rtl/fnv1a_stream_hasher.sv | 162 ++++++++++++++++
 1 files changed

// File: rtl/fnv1a_stream_hasher.sv
// Streaming FNV-1a digest engine with an XOR-LRC side channel.
// Bytes are absorbed over valid/ready; the digest is replayed MSB-first one byte per handshake.
module fnv1a_stream_hasher #(
  parameter int unsigned       HASH_W = 32,
  parameter logic [HASH_W-1:0] OFFSET = HASH_W'(32'h811C9DC5),
  parameter logic [HASH_W-1:0] PRIME  = HASH_W'(32'h01000193),
  parameter int unsigned       CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic [7:0]       in_data,
  input  logic             in_valid,
  input  logic             in_last,
  output logic             in_ready,
  output logic [7:0]       out_data,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic [7:0]       lrc,
  output logic [CNT_W-1:0] byte_count,
  output logic             busy
);

  localparam int unsigned      OUT_BYTES = HASH_W / 8;
  localparam int unsigned      K_W       = (OUT_BYTES > 1) ? $clog2(OUT_BYTES) : 1;
  localparam logic [K_W-1:0]   K_LAST    = K_W'(OUT_BYTES - 1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ABSORB  = 2'd1,
    ST_SQUEEZE = 2'd2
  } state_t;

  state_t            r_state;
  logic [HASH_W-1:0] r_hash;
  logic [K_W-1:0]    r_k;
  logic [7:0]        r_lrc;
  logic [CNT_W-1:0]  r_byte_count;
  logic [7:0]        r_out_data;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              r_out_last;
  logic              r_busy;

  logic              w_in_accept;
  logic              w_out_accept;
  logic [HASH_W-1:0] w_hash_next;
  logic [K_W-1:0]    w_k_next;
  logic [CNT_W-1:0]  w_count_inc;

  // Byte idx of the digest counted from the MSB end.
  function automatic logic [7:0] f_digest_byte(input logic [HASH_W-1:0] h,
                                               input logic [K_W-1:0]    idx);
    logic [HASH_W-1:0] sh;
    sh = h << {idx, 3'b000};
    return sh[HASH_W-1 -: 8];
  endfunction

  assign w_in_accept  = in_valid & r_in_ready;
  assign w_out_accept = r_out_valid & out_ready;
  assign w_hash_next  = (r_hash ^ {{(HASH_W-8){1'b0}}, in_data}) * PRIME;
  assign w_k_next     = r_k + K_W'(1'b1);
  assign w_count_inc  = (r_byte_count == CNT_MAX) ? r_byte_count : r_byte_count + CNT_W'(1'b1);

  // Message FSM: absorb, squeeze and all registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_IDLE;
      r_hash       <= OFFSET;
      r_k          <= {K_W{1'b0}};
      r_lrc        <= 8'h00;
      r_byte_count <= {CNT_W{1'b0}};
      r_out_data   <= 8'h00;
      r_in_ready   <= 1'b0;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_busy       <= 1'b0;
    end else if (clr) begin
      r_state      <= ST_IDLE;
      r_hash       <= OFFSET;
      r_k          <= {K_W{1'b0}};
      r_lrc        <= 8'h00;
      r_byte_count <= {CNT_W{1'b0}};
      r_out_data   <= 8'h00;
      r_in_ready   <= 1'b1;
      r_out_valid  <= 1'b0;
      r_out_last   <= 1'b0;
      r_busy       <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_ABSORB: begin
          if (w_in_accept) begin
            r_hash <= w_hash_next;
            r_busy <= 1'b1;
            // First byte of a message restarts the side statistics.
            if (r_state == ST_IDLE) begin
              r_lrc        <= in_data;
              r_byte_count <= CNT_W'(1'b1);
            end else begin
              r_lrc        <= r_lrc ^ in_data;
              r_byte_count <= w_count_inc;
            end
            if (in_last) begin
              r_state     <= ST_SQUEEZE;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
              r_out_data  <= f_digest_byte(w_hash_next, {K_W{1'b0}});
              r_out_last  <= (K_LAST == {K_W{1'b0}});
              r_k         <= {K_W{1'b0}};
            end else begin
              r_state    <= ST_ABSORB;
              r_in_ready <= 1'b1;
            end
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        ST_SQUEEZE: begin
          if (w_out_accept) begin
            if (r_out_last) begin
              r_state     <= ST_IDLE;
              r_hash      <= OFFSET;
              r_k         <= {K_W{1'b0}};
              r_out_data  <= 8'h00;
              r_out_valid <= 1'b0;
              r_out_last  <= 1'b0;
              r_in_ready  <= 1'b1;
              r_busy      <= 1'b0;
            end else begin
              r_k        <= w_k_next;
              r_out_data <= f_digest_byte(r_hash, w_k_next);
              r_out_last <= (w_k_next == K_LAST);
            end
          end else begin
            r_out_valid <= 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_hash      <= OFFSET;
          r_k         <= {K_W{1'b0}};
          r_out_data  <= 8'h00;
          r_out_valid <= 1'b0;
          r_out_last  <= 1'b0;
          r_in_ready  <= 1'b1;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready   = r_in_ready;
  assign out_data   = r_out_data;
  assign out_valid  = r_out_valid;
  assign out_last   = r_out_last;
  assign lrc        = r_lrc;
  assign byte_count = r_byte_count;
  assign busy       = r_busy;

endmodule
